// File: rtl/serial_sub_pkg.sv
// -----------------------------------------------------------------------------
// serial_sub_pkg
// Shared types for the bit-serial subtractor.
//   state_t   : controller states (IDLE, SHIFT, DONE)
//   cnt_width : width of the bit counter, $clog2(WIDTH+1)
// -----------------------------------------------------------------------------
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/serial_sub_if.sv
// -----------------------------------------------------------------------------
// serial_sub_if
// Start/done handshake and operand/result bus of the serial subtractor.
//   start  : request from the operand side
//   A, B   : minuend / subtrahend
//   busy   : operation in progress
//   done   : one-cycle result strobe
//   D      : difference (A - B) mod 2^WIDTH
//   BO     : borrow out (A < B unsigned)
//   V      : signed overflow of A - B
// master modport drives the request side; slave modport is the subtractor.
// -----------------------------------------------------------------------------
interface serial_sub_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] D;
  logic             BO;
  logic             V;

  modport master (
    output start, A, B,
    input  busy, done, D, BO, V
  );

  modport slave (
    input  start, A, B,
    output busy, done, D, BO, V
  );
endinterface

// File: rtl/serial_sub_full_sub.sv
// -----------------------------------------------------------------------------
// full_sub
// Combinational one-bit full subtractor: A - B - BI.
//   A, B, BI : minuend bit, subtrahend bit, borrow in
//   D        : difference bit  A ^ B ^ BI
//   BO       : borrow out      (~A & B) | (~(A ^ B) & BI)
// Built as two cascaded half subtractors whose borrows are ORed.
// -----------------------------------------------------------------------------
module full_sub (
  input  logic A,
  input  logic B,
  input  logic BI,
  output logic D,
  output logic BO
);

  logic w_d1;
  logic w_b1;
  logic w_b2;

  // first half subtractor: A - B
  assign w_d1 = A ^ B;
  assign w_b1 = ~A & B;

  // second half subtractor: (A - B) - BI
  assign D    = w_d1 ^ BI;
  assign w_b2 = ~w_d1 & BI;

  assign BO   = w_b1 | w_b2;

endmodule

// File: rtl/serial_sub.sv
// -----------------------------------------------------------------------------
// serial_sub
// Bit-serial two's-complement subtractor, D = A - B, LSB first, one bit per
// clock through a single full_sub cell and a registered borrow.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : serial_sub_if.slave (start, A, B in; busy, done, D, BO, V out)
// Accept at edge k -> busy in cycles k+1..k+WIDTH -> done in cycle k+WIDTH+1.
// D/BO/V are loaded on the edge that enters DONE and hold until the next one.
// -----------------------------------------------------------------------------
module serial_sub
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  serial_sub_if.slave  bus
);

  localparam int            CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           r_state;
  state_t           w_next;

  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  logic [WIDTH-1:0] r_res;
  logic             r_a_msb;
  logic             r_b_msb;
  logic             r_borrow;
  logic [CW-1:0]    r_cnt;

  logic [WIDTH-1:0] r_d;
  logic             r_bo;
  logic             r_v;

  logic             w_accept;
  logic             w_shift;
  logic             w_last;
  logic             w_diff;
  logic             w_bout;
  logic             w_busy;
  logic             w_done;

  assign w_accept = (r_state == IDLE) && bus.start;
  assign w_shift  = (r_state == SHIFT);
  assign w_last   = w_shift && (r_cnt == LAST);

  full_sub u_cell (
    .A  (r_sa[0]),
    .B  (r_sb[0]),
    .BI (r_borrow),
    .D  (w_diff),
    .BO (w_bout)
  );

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // FSM: next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (bus.start) w_next = SHIFT;
      SHIFT:   if (w_last)    w_next = DONE;
      DONE:                   w_next = IDLE;
      default:                w_next = IDLE;
    endcase
  end

  // FSM: outputs decoded from the registered state, so busy/done are
  // mutually exclusive and glitch-free with respect to inputs.
  always_comb begin
    w_busy = 1'b0;
    w_done = 1'b0;
    case (r_state)
      SHIFT:   w_busy = 1'b1;
      DONE:    w_done = 1'b1;
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Operand / result shift registers (datapath, no reset)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_sa    <= bus.A;
      r_sb    <= bus.B;
      r_res   <= '0;
      r_a_msb <= bus.A[WIDTH-1];
      r_b_msb <= bus.B[WIDTH-1];
    end else if (w_shift) begin
      r_sa  <= {1'b0, r_sa[WIDTH-1:1]};
      r_sb  <= {1'b0, r_sb[WIDTH-1:1]};
      // difference bits enter at the MSB so bit 0 ends up LSB after WIDTH shifts
      r_res <= {w_diff, r_res[WIDTH-1:1]};
    end
  end

  // ---------------------------------------------------------------------------
  // Borrow flop and bit counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_borrow <= 1'b0;
      r_cnt    <= '0;
    end else if (w_accept) begin
      r_borrow <= 1'b0;
      r_cnt    <= '0;
    end else if (w_shift) begin
      r_borrow <= w_bout;
      r_cnt    <= r_cnt + CW'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Result registers: loaded from the last bit cycle so they change only on
  // the edge entering DONE and never expose a partial result.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_d  <= '0;
      r_bo <= 1'b0;
      r_v  <= 1'b0;
    end else if (w_last) begin
      r_d  <= {w_diff, r_res[WIDTH-1:1]};
      r_bo <= w_bout;
      // overflow only when operand signs differ and the result sign
      // disagrees with the minuend sign; w_diff is the result MSB here
      r_v  <= (r_a_msb ^ r_b_msb) & (w_diff ^ r_a_msb);
    end
  end

  assign bus.busy = w_busy;
  assign bus.done = w_done;
  assign bus.D    = r_d;
  assign bus.BO   = r_bo;
  assign bus.V    = r_v;

endmodule
